// File: rtl/csr_write_unit_pkg.sv
// csr_write_unit_pkg: shared CSR op codes, addresses, privilege levels and register layouts
package csr_write_unit_pkg;
  typedef enum logic [1:0] {CSR_NOP = 2'b00, CSR_RW = 2'b01, CSR_RS = 2'b10, CSR_RC = 2'b11} csr_op_t;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;
  typedef struct packed {
    logic        sd;
    logic [49:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo;
    logic        mie;
    logic [2:0]  rsvd_0;
  } mstatus_t;
  typedef struct packed {
    logic [3:0]  mode;
    logic [15:0] asid;
    logic [43:0] ppn;
  } satp_t;
  typedef enum logic [1:0] {S_IDLE, S_TRAP1, S_TRAP2, S_MRET} state_t;
  function automatic logic [63:0] trap_target(input logic [63:0] mtvec, input logic [63:0] cause);
    return (mtvec[1:0] == 2'b01 && cause[63]) ? (mtvec & ~64'h3) + (cause << 2) : (mtvec & ~64'h3);
  endfunction
endpackage

// File: rtl/csr_write_unit_next_value.sv
// csr_next_value: Zicsr read-modify-write result with per-register write masks
module csr_next_value
  import csr_write_unit_pkg::*;
(
  input  csr_op_t     op_i,
  input  logic [63:0] old_i,
  input  logic [63:0] wdata_i,
  input  logic [11:0] addr_i,
  output logic [63:0] nval_o,
  output logic        we_o
);
  logic [63:0] raw;
  logic        known;
  assign raw = op_i == CSR_RW ? wdata_i : op_i == CSR_RS ? (old_i | wdata_i) : (old_i & ~wdata_i);
  assign nval_o = raw & (addr_i == CSR_MEPC ? ~64'h3 : addr_i == CSR_MTVEC ? ~64'h2 : ~64'h0);
  assign known = addr_i inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                                CSR_MCAUSE, CSR_MTVAL, CSR_SATP};
  assign we_o = op_i != CSR_NOP && known;
endmodule

// File: rtl/csr_write_unit.sv
// csr_write_unit: machine-mode CSR state owner handling Zicsr writes, trap entry and MRET
module csr_write_unit
  import csr_write_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_old,
  input  logic        trap_valid,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_tval,
  input  logic        mret_valid,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy,
  output logic [63:0] csr_mstatus,
  output logic [63:0] csr_mtvec,
  output logic [63:0] csr_mepc,
  output logic [63:0] csr_satp,
  output logic [1:0]  priv_mode
);
  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  mstatus_t    mstatus_q, mstatus_d;
  satp_t       satp_q, satp_d;
  logic [63:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] tpc_q, tcause_q, ttval_q;
  logic        resp_valid_q;
  logic [63:0] resp_old_q, old_val, nval;
  logic        idle, wr_fire, nv_we;
  assign idle      = state_q == S_IDLE;
  assign req_ready = idle & ~trap_valid & ~mret_valid;
  assign wr_fire   = req_valid & req_ready;
  always_comb begin
    old_val = '0;
    case (req_addr)
      CSR_MSTATUS:  old_val = mstatus_q;
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      CSR_SATP:     old_val = satp_q;
      default:      old_val = '0;
    endcase
  end
  csr_next_value u_nv (
    .op_i(csr_op_t'(req_op)), .old_i(old_val), .wdata_i(req_wdata), .addr_i(req_addr),
    .nval_o(nval), .we_o(nv_we)
  );
  assign state_d = idle ? (trap_valid ? S_TRAP1 : mret_valid ? S_MRET : S_IDLE) :
                   state_q == S_TRAP1 ? S_TRAP2 : S_IDLE;
  always_comb begin
    mode_d = mode_q; mstatus_d = mstatus_q; mie_d = mie_q; mtvec_d = mtvec_q;
    mscratch_d = mscratch_q; mepc_d = mepc_q; mcause_d = mcause_q; mtval_d = mtval_q;
    satp_d = satp_q;
    if (wr_fire && nv_we) begin
      case (req_addr)
        CSR_MSTATUS:  mstatus_d = mstatus_t'(nval);
        CSR_MIE:      mie_d = nval;
        CSR_MTVEC:    mtvec_d = nval;
        CSR_MSCRATCH: mscratch_d = nval;
        CSR_MEPC:     mepc_d = nval;
        CSR_MCAUSE:   mcause_d = nval;
        CSR_MTVAL:    mtval_d = nval;
        CSR_SATP:     satp_d = satp_t'(nval);
        default:      ;
      endcase
    end
    if (state_q == S_TRAP1) begin
      mepc_d = tpc_q & ~64'h3;
      mcause_d = tcause_q;
      mtval_d = ttval_q;
    end
    if (state_q == S_TRAP2) begin
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie = 1'b0;
      mstatus_d.mpp = mode_q;
      mode_d = PRIV_M;
    end
    if (state_q == S_MRET) begin
      mstatus_d.mie = mstatus_q.mpie;
      mstatus_d.mpie = 1'b1;
      mstatus_d.mpp = PRIV_U;
      mode_d = mstatus_q.mpp;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE; mode_q <= PRIV_M; mstatus_q <= '0; satp_q <= '0;
      mie_q <= '0; mtvec_q <= '0; mscratch_q <= '0; mepc_q <= '0; mcause_q <= '0; mtval_q <= '0;
      tpc_q <= '0; tcause_q <= '0; ttval_q <= '0;
      resp_valid_q <= 1'b0; resp_old_q <= '0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; mstatus_q <= mstatus_d; satp_q <= satp_d;
      mie_q <= mie_d; mtvec_q <= mtvec_d; mscratch_q <= mscratch_d; mepc_q <= mepc_d;
      mcause_q <= mcause_d; mtval_q <= mtval_d;
      resp_valid_q <= wr_fire;
      if (wr_fire) resp_old_q <= old_val;
      if (idle && trap_valid) begin
        tpc_q <= trap_pc; tcause_q <= trap_cause; ttval_q <= trap_tval;
      end
    end
  end
  assign resp_valid     = resp_valid_q;
  assign resp_old       = resp_old_q;
  assign busy           = !idle;
  assign redirect_valid = state_q == S_TRAP2 || state_q == S_MRET;
  assign redirect_pc    = state_q == S_TRAP2 ? trap_target(mtvec_q, mcause_q) :
                          state_q == S_MRET ? mepc_q : '0;
  assign csr_mstatus    = mstatus_q;
  assign csr_mtvec      = mtvec_q;
  assign csr_mepc       = mepc_q;
  assign csr_satp       = satp_q;
  assign priv_mode      = mode_q;
endmodule

// File: tb/tb_csr_write_unit.sv
// tb_csr_write_unit: randomized and directed checks of csr_write_unit against an address-keyed CSR model
module tb_csr_write_unit;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_ready, resp_valid, trap_valid = 0, mret_valid = 0;
  logic redirect_valid, busy;
  logic [1:0]  req_op = 0, priv_mode;
  logic [11:0] req_addr = 0;
  logic [63:0] req_wdata = 0, resp_old, trap_cause = 0, trap_pc = 0, trap_tval = 0, redirect_pc;
  logic [63:0] csr_mstatus, csr_mtvec, csr_mepc, csr_satp;
  int total = 0, bad = 0;
  logic [63:0] csr [logic [11:0]];
  logic [1:0]  mode_m;
  logic [11:0] addrs [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h180};

  csr_write_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_old(resp_old),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .csr_mstatus(csr_mstatus), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_satp(csr_satp), .priv_mode(priv_mode)
  );

  always #5 clk = ~clk;

  function automatic void mdl_reset();
    foreach (addrs[i]) csr[addrs[i]] = 64'h0;
    mode_m = 2'b11;
  endfunction

  function automatic logic [63:0] mdl_write(input logic [1:0] op, input logic [11:0] a, input logic [63:0] w);
    logic [63:0] old, nv;
    if (!csr.exists(a)) return 64'h0;
    old = csr[a];
    if (op == 2'b00) return old;
    nv = op == 2'b01 ? w : op == 2'b10 ? (old | w) : (old & ~w);
    if (a == 12'h341) nv[1:0] = 2'b00;
    if (a == 12'h305) nv[1] = 1'b0;
    if (a != 12'h344) csr[a] = nv;
    return old;
  endfunction

  function automatic logic [63:0] mdl_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
    logic [63:0] ms, tv;
    csr[12'h341] = pc & ~64'h3;
    csr[12'h342] = cause;
    csr[12'h343] = tval;
    ms = csr[12'h300];
    ms[7] = ms[3];
    ms[3] = 1'b0;
    ms[12:11] = mode_m;
    mode_m = 2'b11;
    csr[12'h300] = ms;
    tv = csr[12'h305];
    return (tv[1:0] == 2'b01 && cause[63]) ? (tv & ~64'h3) + cause * 64'd4 : (tv & ~64'h3);
  endfunction

  function automatic logic [63:0] mdl_mret();
    logic [63:0] ms;
    ms = csr[12'h300];
    ms[3] = ms[7];
    ms[7] = 1'b1;
    mode_m = ms[12:11];
    ms[12:11] = 2'b00;
    csr[12'h300] = ms;
    return csr[12'h341];
  endfunction

  task automatic do_write(input logic [1:0] op, input logic [11:0] a, input logic [63:0] w,
                          output logic rv, output logic [63:0] ro);
    req_valid = 1; req_op = op; req_addr = a; req_wdata = w;
    @(negedge clk);
    rv = resp_valid; ro = resp_old;
    req_valid = 0;
  endtask

  task automatic test_reset();
    total++; if (priv_mode !== 2'b11) begin bad++; $display("FAIL reset_priv got=%h exp=3", priv_mode); end
    total++; if ({csr_mstatus, csr_mtvec, csr_mepc, csr_satp} !== 256'h0) begin bad++; $display("FAIL reset_csrs got=%h %h %h %h exp=0", csr_mstatus, csr_mtvec, csr_mepc, csr_satp); end
    total++; if ({req_ready, busy, resp_valid, redirect_valid} !== 4'b1000) begin bad++; $display("FAIL reset_flags got=%b exp=1000", {req_ready, busy, resp_valid, redirect_valid}); end
    total++; if ({resp_old, redirect_pc} !== 128'h0) begin bad++; $display("FAIL reset_data got=%h %h exp=0", resp_old, redirect_pc); end
  endtask

  task automatic test_csr_ops();
    logic rv; logic [63:0] ro, exp;
    exp = mdl_write(2'b01, 12'h305, 64'h8000_0003);
    do_write(2'b01, 12'h305, 64'h8000_0003, rv, ro);
    total++; if (rv !== 1'b1 || ro !== exp) begin bad++; $display("FAIL rw_mtvec_old got=%b/%h exp=1/%h", rv, ro, exp); end
    total++; if (csr_mtvec !== csr[12'h305]) begin bad++; $display("FAIL rw_mtvec_val got=%h exp=%h", csr_mtvec, csr[12'h305]); end
    void'(mdl_write(2'b10, 12'h340, 64'hF0));
    do_write(2'b10, 12'h340, 64'hF0, rv, ro);
    void'(mdl_write(2'b11, 12'h340, 64'h30));
    do_write(2'b11, 12'h340, 64'h30, rv, ro);
    total++; if (ro !== 64'hF0) begin bad++; $display("FAIL rc_mscratch_old got=%h exp=f0", ro); end
    exp = mdl_write(2'b00, 12'h340, 64'hFFFF);
    do_write(2'b00, 12'h340, 64'hFFFF, rv, ro);
    total++; if (rv !== 1'b1 || ro !== exp) begin bad++; $display("FAIL nop_mscratch got=%b/%h exp=1/%h", rv, ro, exp); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse got=%b exp=0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2, w1, w2;
    w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom};
    e1 = mdl_write(2'b01, 12'h340, w1);
    e2 = mdl_write(2'b10, 12'h340, w2);
    req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_wdata = w1;
    @(negedge clk);
    total++; if (resp_valid !== 1'b1 || resp_old !== e1) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/%h", resp_valid, resp_old, e1); end
    req_op = 2'b10; req_wdata = w2;
    @(negedge clk);
    req_valid = 0;
    total++; if (resp_valid !== 1'b1 || resp_old !== e2) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/%h", resp_valid, resp_old, e2); end
  endtask

  task automatic test_unknown();
    logic rv; logic [63:0] ro, w;
    w = {$urandom, $urandom};
    void'(mdl_write(2'b01, 12'h7C0, w));
    do_write(2'b01, 12'h7C0, w, rv, ro);
    total++; if (rv !== 1'b1 || ro !== 64'h0) begin bad++; $display("FAIL unknown_old got=%b/%h exp=1/0", rv, ro); end
    total++; if ({csr_mstatus, csr_mtvec, csr_mepc, csr_satp} !== {csr[12'h300], csr[12'h305], csr[12'h341], csr[12'h180]}) begin bad++; $display("FAIL unknown_nochange got=%h %h %h %h", csr_mstatus, csr_mtvec, csr_mepc, csr_satp); end
    void'(mdl_write(2'b01, 12'h344, ~64'h0));
    do_write(2'b01, 12'h344, ~64'h0, rv, ro);
    do_write(2'b00, 12'h344, 64'h0, rv, ro);
    total++; if (ro !== csr[12'h344]) begin bad++; $display("FAIL mip_ignored got=%h exp=%h", ro, csr[12'h344]); end
  endtask

  task automatic test_random();
    logic rv; logic [63:0] ro, exp, w; logic [1:0] op; logic [11:0] a; int idx;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      idx = $urandom_range(0, 9);
      a = idx == 9 ? 12'h7C0 : addrs[idx];
      w = {$urandom, $urandom};
      exp = mdl_write(op, a, w);
      do_write(op, a, w, rv, ro);
      total++; if (rv !== 1'b1 || ro !== exp) begin bad++; $display("FAIL rand_old[%0d] op=%0d a=%h got=%b/%h exp=1/%h", i, op, a, rv, ro, exp); end
      total++; if ({csr_mstatus, csr_mtvec, csr_mepc, csr_satp} !== {csr[12'h300], csr[12'h305], csr[12'h341], csr[12'h180]}) begin bad++; $display("FAIL rand_state[%0d] got=%h %h %h %h exp=%h %h %h %h", i, csr_mstatus, csr_mtvec, csr_mepc, csr_satp, csr[12'h300], csr[12'h305], csr[12'h341], csr[12'h180]); end
    end
  endtask

  task automatic run_trap(input string nm, input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
    logic rv; logic [63:0] ro, tgt;
    trap_valid = 1; trap_pc = pc; trap_cause = cause; trap_tval = tval;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL %s_ready got=%b exp=0", nm, req_ready); end
    tgt = mdl_trap(pc, cause, tval);
    @(negedge clk);
    trap_valid = 0; mret_valid = 0;
    total++; if ({busy, redirect_valid, resp_valid} !== 3'b100) begin bad++; $display("FAIL %s_n1 busy/redir/resp got=%b exp=100", nm, {busy, redirect_valid, resp_valid}); end
    @(negedge clk);
    req_valid = 0;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== tgt) begin bad++; $display("FAIL %s_redirect got=%b/%h exp=1/%h", nm, redirect_valid, redirect_pc, tgt); end
    total++; if (csr_mepc !== csr[12'h341] || busy !== 1'b1) begin bad++; $display("FAIL %s_mepc got=%h busy=%b exp=%h", nm, csr_mepc, busy, csr[12'h341]); end
    @(negedge clk);
    total++; if ({busy, redirect_valid} !== 2'b00) begin bad++; $display("FAIL %s_done got=%b exp=00", nm, {busy, redirect_valid}); end
    total++; if (csr_mstatus !== csr[12'h300] || priv_mode !== mode_m) begin bad++; $display("FAIL %s_mstatus got=%h/%h exp=%h/%h", nm, csr_mstatus, priv_mode, csr[12'h300], mode_m); end
    do_write(2'b00, 12'h342, 64'h0, rv, ro);
    total++; if (ro !== csr[12'h342]) begin bad++; $display("FAIL %s_mcause got=%h exp=%h", nm, ro, csr[12'h342]); end
    do_write(2'b00, 12'h343, 64'h0, rv, ro);
    total++; if (ro !== csr[12'h343]) begin bad++; $display("FAIL %s_mtval got=%h exp=%h", nm, ro, csr[12'h343]); end
  endtask

  task automatic test_trap();
    logic rv; logic [63:0] ro;
    void'(mdl_write(2'b01, 12'h305, 64'h8000_0000));
    do_write(2'b01, 12'h305, 64'h8000_0000, rv, ro);
    void'(mdl_write(2'b01, 12'h300, 64'h8));
    do_write(2'b01, 12'h300, 64'h8, rv, ro);
    run_trap("trap", 64'h8000_1002, 64'd2, {$urandom, $urandom});
  endtask

  task automatic test_mret();
    logic [63:0] exp;
    mret_valid = 1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mret_ready got=%b exp=0", req_ready); end
    exp = mdl_mret();
    @(negedge clk);
    mret_valid = 0;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== exp || busy !== 1'b1) begin bad++; $display("FAIL mret_redirect got=%b/%h busy=%b exp=1/%h", redirect_valid, redirect_pc, busy, exp); end
    @(negedge clk);
    total++; if ({busy, redirect_valid} !== 2'b00) begin bad++; $display("FAIL mret_done got=%b exp=00", {busy, redirect_valid}); end
    @(negedge clk);
    total++; if (csr_mstatus !== csr[12'h300] || priv_mode !== mode_m) begin bad++; $display("FAIL mret_state got=%h/%h exp=%h/%h", csr_mstatus, priv_mode, csr[12'h300], mode_m); end
  endtask

  task automatic test_vectored();
    logic rv; logic [63:0] ro;
    void'(mdl_write(2'b01, 12'h305, 64'h8000_0001));
    do_write(2'b01, 12'h305, 64'h8000_0001, rv, ro);
    run_trap("vec", {$urandom, $urandom}, (64'h1 << 63) | 64'd7, 64'h0);
    void'(mdl_write(2'b01, 12'h305, 64'h1234_5671));
    do_write(2'b01, 12'h305, 64'h1234_5671, rv, ro);
    run_trap("vecsync", {$urandom, $urandom}, 64'd11, {$urandom, $urandom});
  endtask

  task automatic test_priority();
    logic rv; logic [63:0] ro;
    req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_wdata = 64'hDEAD;
    mret_valid = 1;
    run_trap("prio", {$urandom, $urandom}, 64'd5, 64'h77);
    do_write(2'b00, 12'h340, 64'h0, rv, ro);
    total++; if (ro !== csr[12'h340]) begin bad++; $display("FAIL prio_req_dropped got=%h exp=%h", ro, csr[12'h340]); end
  endtask

  task automatic test_reset_mid_trap();
    logic rv; logic [63:0] ro;
    trap_valid = 1; trap_pc = 64'h4000; trap_cause = 64'd3; trap_tval = 64'h9;
    @(negedge clk);
    trap_valid = 0;
    reset = 0;
    #1;
    mdl_reset();
    total++; if ({busy, redirect_valid} !== 2'b00 || priv_mode !== 2'b11) begin bad++; $display("FAIL rst_mid_flags got=%b/%h exp=00/3", {busy, redirect_valid}, priv_mode); end
    total++; if ({csr_mstatus, csr_mtvec, csr_mepc, csr_satp} !== 256'h0) begin bad++; $display("FAIL rst_mid_csrs got=%h %h %h %h exp=0", csr_mstatus, csr_mtvec, csr_mepc, csr_satp); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    total++; if (redirect_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_after got=%b/%b exp=0/1", redirect_valid, req_ready); end
    do_write(2'b00, 12'h342, 64'h0, rv, ro);
    total++; if (ro !== csr[12'h342]) begin bad++; $display("FAIL rst_mid_mcause got=%h exp=%h", ro, csr[12'h342]); end
  endtask

  initial begin
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    test_reset();
    test_csr_ops();
    test_back_to_back();
    test_unknown();
    test_random();
    test_trap();
    test_mret();
    test_vectored();
    test_priority();
    test_reset_mid_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
